// File: rtl/rx_strobe_sequencer.sv
// Receive-chain strobe scheduler: clk_int / sam_clk / sym_clk enables plus the clear_accum window-end pulse.
// Latency 1 clk from start/stop/sync; no backpressure, every output is a flop decoded from next-state.
module rx_strobe_sequencer #(
    parameter int INT_DIV  = 2,
    parameter int SAM_DIV  = 2,
    parameter int SPS      = 4,
    parameter int SPS_W    = 2,
    parameter int ACC_SYMS = 256,
    parameter int ACC_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             sync,
    input  logic [SPS_W-1:0] phase_sel,
    output logic             clk_int,
    output logic             sam_clk,
    output logic             sym_clk,
    output logic             clear_accum,
    output logic             running,
    output logic [ACC_W-1:0] sym_idx
);
    localparam int G      = INT_DIV * SAM_DIV;
    localparam int P      = G * SPS;
    localparam int MCNT_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(P - 1);
    localparam logic [ACC_W-1:0]  IDX_LAST  = ACC_W'(ACC_SYMS - 1);
    localparam logic [SPS_W-1:0]  PH_MAX    = SPS_W'(SPS - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [ACC_W-1:0]  sym_idx_q, sym_idx_d;
    logic [SPS_W-1:0]  phase_q, phase_d, phase_sel_c;
    logic              clk_int_q, clk_int_d;
    logic              sam_clk_q, sam_clk_d;
    logic              sym_clk_q, sym_clk_d;
    logic              clear_q, clear_d;
    logic              run_d;

    assign phase_sel_c = (32'(phase_sel) >= SPS) ? PH_MAX : phase_sel;

    always_comb begin
        state_d   = state_q;
        mcnt_d    = mcnt_q;
        sym_idx_d = sym_idx_q;
        phase_d   = phase_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d   = RUN;
                    mcnt_d    = '0;
                    sym_idx_d = '0;
                    phase_d   = phase_sel_c;
                end
            end
            default: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    mcnt_d = (mcnt_q == MCNT_LAST) ? '0 : mcnt_q + MCNT_W'(1);
                    if (sym_clk_q) begin
                        sym_idx_d = (sym_idx_q == IDX_LAST) ? '0 : sym_idx_q + ACC_W'(1);
                    end
                    // Phase only changes on a period boundary so each period has exactly one sym_clk.
                    if (mcnt_q == MCNT_LAST) begin
                        phase_d = phase_sel_c;
                    end
                end
            end
        endcase
        if (sync) begin
            mcnt_d    = '0;
            sym_idx_d = '0;
        end
    end

    assign run_d     = (state_d == RUN);
    assign clk_int_d = run_d && ((32'(mcnt_d) % INT_DIV) == INT_DIV - 1);
    assign sam_clk_d = run_d && ((32'(mcnt_d) % G) == G - 1);
    assign sym_clk_d = run_d && (32'(mcnt_d) == G * 32'(phase_d) + G - 1);
    assign clear_d   = sym_clk_d && (sym_idx_d == IDX_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mcnt_q    <= '0;
            sym_idx_q <= '0;
            phase_q   <= '0;
            clk_int_q <= 1'b0;
            sam_clk_q <= 1'b0;
            sym_clk_q <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcnt_q    <= mcnt_d;
            sym_idx_q <= sym_idx_d;
            phase_q   <= phase_d;
            clk_int_q <= clk_int_d;
            sam_clk_q <= sam_clk_d;
            sym_clk_q <= sym_clk_d;
            clear_q   <= clear_d;
        end
    end

    assign clk_int     = clk_int_q;
    assign sam_clk     = sam_clk_q;
    assign sym_clk     = sym_clk_q;
    assign clear_accum = clear_q;
    assign running     = (state_q == RUN);
    assign sym_idx     = sym_idx_q;

endmodule

// File: tb/tb_rx_strobe_sequencer.sv
// Directed bench for rx_strobe_sequencer with default parameters (period 16, 256-symbol window).
module tb_rx_strobe_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       sync;
    logic [1:0] phase_sel;
    logic       clk_int;
    logic       sam_clk;
    logic       sym_clk;
    logic       clear_accum;
    logic       running;
    logic [7:0] sym_idx;

    int checks   = 0;
    int errors   = 0;
    int mc       = 0;
    int nsym     = 0;
    int clr_seen = 0;
    int cyc      = 0;
    int clr_last = -1;
    int clr_prev = -1;

    always #5 clk = ~clk;

    rx_strobe_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .sync        (sync),
        .phase_sel   (phase_sel),
        .clk_int     (clk_int),
        .sam_clk     (sam_clk),
        .sym_clk     (sym_clk),
        .clear_accum (clear_accum),
        .running     (running),
        .sym_idx     (sym_idx)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s mc=%0d: observed %b expected %b", tag, mc, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s mc=%0d: observed %0d expected %0d", tag, mc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Running cycles: mc/nsym track the expected master count and symbol index.
    task automatic run_cycles(input int n, input int sym_at);
        for (int i = 0; i < n; i++) begin
            logic e_sym;
            e_sym = (mc == sym_at);
            chk_b("running", running, 1'b1);
            chk_b("clk_int", clk_int, (mc % 2) == 1);
            chk_b("sam_clk", sam_clk, (mc % 4) == 3);
            chk_b("sym_clk", sym_clk, e_sym);
            chk_b("clear_accum", clear_accum, e_sym && (nsym == 255));
            chk_v("sym_idx", 32'(sym_idx), 32'(nsym));
            if (clear_accum) begin
                clr_seen++;
                clr_prev = clr_last;
                clr_last = cyc;
            end
            if (e_sym) nsym = (nsym + 1) % 256;
            mc = (mc + 1) % 16;
            step();
        end
    endtask

    task automatic idle_checks(input int n, input int idx);
        for (int i = 0; i < n; i++) begin
            chk_b("idle_running", running, 1'b0);
            chk_b("idle_clk_int", clk_int, 1'b0);
            chk_b("idle_sam_clk", sam_clk, 1'b0);
            chk_b("idle_sym_clk", sym_clk, 1'b0);
            chk_b("idle_clear", clear_accum, 1'b0);
            chk_v("idle_sym_idx", 32'(sym_idx), 32'(idx));
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        sync      = 1'b0;
        phase_sel = 2'd0;
        step();
        step();
        chk_b("rst_clk_int", clk_int, 1'b0);
        chk_b("rst_sam_clk", sam_clk, 1'b0);
        chk_b("rst_sym_clk", sym_clk, 1'b0);
        chk_b("rst_clear", clear_accum, 1'b0);
        chk_b("rst_running", running, 1'b0);
        chk_v("rst_sym_idx", 32'(sym_idx), 32'd0);
        reset = 1'b1;
        idle_checks(3, 0);

        // Start with phase 0: sym_clk at mcnt 3.
        start = 1'b1;
        step();
        start = 1'b0;
        mc = 0;
        nsym = 0;
        run_cycles(32, 3);

        // Phase change mid-period takes effect only at the next period.
        run_cycles(5, 3);
        phase_sel = 2'd2;
        run_cycles(11, 3);
        run_cycles(5, 11);
        phase_sel = 2'd3;
        run_cycles(11, 11);
        run_cycles(16, 15);

        // 507 periods from sym_idx 5: windows close at two points 4096 clk apart.
        run_cycles(507 * 16, 15);
        chk_v("clear_count", 32'(clr_seen), 32'd2);
        chk_v("clear_spacing", 32'(clr_last - clr_prev), 32'd4096);
        chk_v("idx_after_wrap", 32'(sym_idx), 32'd0);

        // Sync at mcnt 9 in the last symbol period of a window: no clear_accum.
        run_cycles(255 * 16, 15);
        run_cycles(9, 15);
        sync = 1'b1;
        run_cycles(1, 15);
        sync = 1'b0;
        mc = 0;
        nsym = 0;
        run_cycles(16, 15);
        chk_v("clear_after_sync", 32'(clr_seen), 32'd2);

        // Start while running is ignored; stop freezes counters.
        run_cycles(5, 15);
        start = 1'b1;
        run_cycles(1, 15);
        start = 1'b0;
        run_cycles(1, 15);
        stop = 1'b1;
        run_cycles(1, 15);
        stop = 1'b0;
        idle_checks(3, 1);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        idle_checks(3, 1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        idle_checks(2, 0);

        phase_sel = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        mc = 0;
        nsym = 0;
        run_cycles(16, 3);
        run_cycles(7, 3);

        // Async reset mid-cycle at mcnt 7.
        chk_b("pre_reset_clk_int", clk_int, 1'b1);
        chk_v("pre_reset_sym_idx", 32'(sym_idx), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_b("arst_clk_int", clk_int, 1'b0);
        chk_b("arst_sam_clk", sam_clk, 1'b0);
        chk_b("arst_sym_clk", sym_clk, 1'b0);
        chk_b("arst_clear", clear_accum, 1'b0);
        chk_b("arst_running", running, 1'b0);
        chk_v("arst_sym_idx", 32'(sym_idx), 32'd0);
        #2;
        reset = 1'b1;
        step();
        idle_checks(4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
